// File: rtl/arb_pkg.sv
// arb_pkg: shared arbitration mode and FSM state types.
package arb_pkg;
   typedef enum logic {ARB_RR, ARB_FIXED} arb_mode_e;
   typedef enum logic {ARB, HOLD} arb_state_e;
endpackage

// File: rtl/prio_arb_core.sv
// prio_arb_core: combinational rotating-priority search from a one-hot start position.
module prio_arb_core #(
   parameter int N = 4
) (
   input  logic [N-1:0] req_i,
   input  logic [N-1:0] start_i,
   output logic [N-1:0] gnt_o,
   output logic         any_o
);
   logic [2*N-1:0] dreq, dgnt;
   // Doubling the request vector turns the wrap-around search into a borrow chain.
   assign dreq  = {req_i, req_i};
   assign dgnt  = dreq & ~(dreq - {{N{1'b0}}, start_i});
   assign gnt_o = dgnt[N-1:0] | dgnt[2*N-1:N];
   assign any_o = |req_i;
endmodule

// File: rtl/rr_burst_arbiter.sv
// rr_burst_arbiter: round-robin/fixed-priority arbiter with burst tenure and lock hold.
module rr_burst_arbiter import arb_pkg::*; #(
   parameter int        N     = 4,
   parameter int        BURST = 1,
   parameter arb_mode_e MODE  = ARB_RR
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N-1:0]         request_i,
   input  logic [N-1:0]         lock_i,
   input  logic                 ready_i,
   output logic [N-1:0]         grant_o,
   output logic [$clog2(N)-1:0] grant_idx_o,
   output logic                 anygnt_o,
   output logic                 hold_o
);
   localparam int             IW   = $clog2(N);
   localparam int             CW   = $clog2(BURST) + 1;
   localparam logic [N-1:0]   LSB  = 1;
   localparam logic [IW-1:0]  IONE = 1;
   localparam logic [CW-1:0]  CONE = 1;
   arb_state_e    state_q, state_d;
   logic [IW-1:0] ptr_q, ptr_d, owner_q, owner_d, ptr_eff;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [N-1:0]  core_gnt;
   logic          core_any, in_hold, accept;
   function automatic logic [IW-1:0] nxt_ptr(input logic [IW-1:0] v);
      return (MODE == ARB_FIXED || int'(v) == N - 1) ? '0 : v + IONE;
   endfunction
   // Reset forces the ARB view with ptr=0 even before the registers clear.
   assign ptr_eff = rst ? '0 : ptr_q;
   assign in_hold = (state_q == HOLD) && !rst;
   prio_arb_core #(.N(N)) u_core (
      .req_i  (request_i),
      .start_i(LSB << ptr_eff),
      .gnt_o  (core_gnt),
      .any_o  (core_any)
   );
   assign grant_o  = in_hold ? (LSB << owner_q) & request_i : core_gnt;
   assign anygnt_o = in_hold ? request_i[owner_q] : core_any;
   assign hold_o   = in_hold;
   assign accept   = anygnt_o & ready_i;
   always_comb begin
      grant_idx_o = '0;
      for (int i = 0; i < N; i++)
         grant_idx_o = grant_o[i] ? grant_idx_o | IW'(i) : grant_idx_o;
   end
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      owner_d = owner_q;
      cnt_d   = cnt_q;
      if (state_q == ARB) begin
         if (accept && (lock_i[grant_idx_o] || BURST > 1)) begin
            state_d = HOLD;
            owner_d = grant_idx_o;
            cnt_d   = CONE;
         end else if (accept) begin
            ptr_d = nxt_ptr(grant_idx_o);
         end
      end else if (!request_i[owner_q] || (accept && !lock_i[owner_q] && int'(cnt_q) + 1 >= BURST)) begin
         state_d = ARB;
         ptr_d   = nxt_ptr(owner_q);
         cnt_d   = '0;
      end else if (accept) begin
         cnt_d = (int'(cnt_q) >= BURST) ? cnt_q : cnt_q + CONE;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ARB;
         ptr_q   <= '0;
         owner_q <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         owner_q <= owner_d;
         cnt_q   <= cnt_d;
      end
   end
endmodule

// File: tb/tb_rr_burst_arbiter.sv
// tb_rr_burst_arbiter: scoreboard bench over RR/BURST=1, RR/BURST=2 and FIXED instances.
module tb_rr_burst_arbiter;
   import arb_pkg::*;
   typedef struct {
      int       sel;
      logic [3:0] g;
      logic     h;
      string    tag;
   } exp_t;
   logic clk = 1'b0, rst = 1'b1;
   logic [3:0] req[3], lck[3], g[3];
   logic       rdy[3], h[3], a[3];
   logic [1:0] gi[3];
   exp_t sb[$];
   int nvec = 0, nerr = 0;
   always #5 clk = ~clk;
   rr_burst_arbiter #(.N(4), .BURST(1), .MODE(ARB_RR)) u_rr1 (
      .clk(clk), .rst(rst), .request_i(req[0]), .lock_i(lck[0]), .ready_i(rdy[0]),
      .grant_o(g[0]), .grant_idx_o(gi[0]), .anygnt_o(a[0]), .hold_o(h[0]));
   rr_burst_arbiter #(.N(4), .BURST(2), .MODE(ARB_RR)) u_rr2 (
      .clk(clk), .rst(rst), .request_i(req[1]), .lock_i(lck[1]), .ready_i(rdy[1]),
      .grant_o(g[1]), .grant_idx_o(gi[1]), .anygnt_o(a[1]), .hold_o(h[1]));
   rr_burst_arbiter #(.N(4), .BURST(1), .MODE(ARB_FIXED)) u_fix (
      .clk(clk), .rst(rst), .request_i(req[2]), .lock_i(lck[2]), .ready_i(rdy[2]),
      .grant_o(g[2]), .grant_idx_o(gi[2]), .anygnt_o(a[2]), .hold_o(h[2]));
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   function automatic logic [31:0] oh2i(input logic [3:0] v);
      for (int i = 0; i < 4; i++)
         if (v[i]) return i;
      return 0;
   endfunction
   task automatic drive(input int sel, input logic r, input logic [3:0] rq, input logic [3:0] lk,
                        input logic rd, input logic [3:0] eg, input logic eh, input string tag);
      exp_t e;
      @(posedge clk);
      #1;
      rst = r;
      for (int i = 0; i < 3; i++) begin
         req[i] = (i == sel) ? rq : 4'b0;
         lck[i] = (i == sel) ? lk : 4'b0;
         rdy[i] = (i == sel) ? rd : 1'b0;
      end
      e.sel = sel;
      e.g   = eg;
      e.h   = eh;
      e.tag = tag;
      sb.push_back(e);
   endtask
   always @(negedge clk) begin
      if (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         check({e.tag, ".grant"}, 32'(g[e.sel]), 32'(e.g));
         check({e.tag, ".hold"}, 32'(h[e.sel]), 32'(e.h));
         check({e.tag, ".idx"}, 32'(gi[e.sel]), oh2i(e.g));
         check({e.tag, ".any"}, 32'(a[e.sel]), 32'(|e.g));
      end
   end
   initial begin
      for (int i = 0; i < 3; i++) begin
         req[i] = '0;
         lck[i] = '0;
         rdy[i] = 1'b0;
      end
      drive(0, 1, 4'b1111, 4'b0000, 1, 4'b0001, 0, "rst_view");
      drive(0, 0, 4'b1111, 4'b0000, 1, 4'b0001, 0, "rr_c0");
      drive(0, 0, 4'b1111, 4'b0000, 1, 4'b0010, 0, "rr_c1");
      drive(0, 0, 4'b1111, 4'b0000, 1, 4'b0100, 0, "rr_c2");
      drive(0, 0, 4'b1111, 4'b0000, 1, 4'b1000, 0, "rr_c3");
      drive(0, 0, 4'b1111, 4'b0000, 1, 4'b0001, 0, "rr_wrap");
      drive(0, 0, 4'b0000, 4'b0000, 1, 4'b0000, 0, "no_req");
      for (int k = 0; k < 3; k++)
         drive(0, 0, 4'b1010, 4'b0000, 0, 4'b0010, 0, "stall");
      drive(0, 0, 4'b1010, 4'b0000, 1, 4'b0010, 0, "stall_acc");
      drive(0, 0, 4'b1010, 4'b0000, 1, 4'b1000, 0, "stall_next");
      drive(0, 0, 4'b1010, 4'b0000, 0, 4'b0010, 0, "drop_pre");
      drive(0, 0, 4'b1000, 4'b0000, 0, 4'b1000, 0, "drop_move");
      drive(0, 0, 4'b1000, 4'b0000, 1, 4'b1000, 0, "drop_acc");
      drive(0, 0, 4'b0001, 4'b0000, 1, 4'b0001, 0, "to_ptr1");
      drive(0, 0, 4'b1100, 4'b0100, 1, 4'b0100, 0, "lock_win");
      for (int k = 0; k < 4; k++)
         drive(0, 0, 4'b1100, 4'b0100, 1, 4'b0100, 1, "lock_hold");
      drive(0, 0, 4'b1100, 4'b0000, 1, 4'b0100, 1, "lock_rel");
      drive(0, 0, 4'b1100, 4'b0000, 1, 4'b1000, 0, "lock_after");
      drive(1, 0, 4'b0110, 4'b0000, 1, 4'b0010, 0, "b2_c0");
      drive(1, 0, 4'b0110, 4'b0000, 1, 4'b0010, 1, "b2_c1");
      drive(1, 0, 4'b0110, 4'b0000, 1, 4'b0100, 0, "b2_c2");
      drive(1, 0, 4'b0110, 4'b0000, 1, 4'b0100, 1, "b2_c3");
      drive(1, 0, 4'b0110, 4'b0000, 1, 4'b0010, 0, "b2_c4");
      drive(1, 0, 4'b1001, 4'b0000, 1, 4'b0000, 1, "bubble");
      drive(1, 0, 4'b1001, 4'b0000, 1, 4'b1000, 0, "after_bubble");
      drive(1, 0, 4'b1001, 4'b0000, 0, 4'b1000, 1, "hold_stall");
      drive(1, 0, 4'b1001, 4'b0000, 1, 4'b1000, 1, "hold_acc");
      drive(1, 0, 4'b0110, 4'b0000, 1, 4'b0010, 0, "pre_rst");
      drive(1, 1, 4'b0110, 4'b0000, 1, 4'b0010, 0, "rst_in_hold");
      drive(1, 0, 4'b1100, 4'b0000, 1, 4'b0100, 0, "post_rst");
      drive(2, 0, 4'b1111, 4'b0000, 1, 4'b0001, 0, "fix_c0");
      drive(2, 0, 4'b1111, 4'b0000, 1, 4'b0001, 0, "fix_c1");
      drive(2, 0, 4'b0011, 4'b0000, 1, 4'b0001, 0, "fix_c2");
      drive(2, 0, 4'b1111, 4'b0001, 1, 4'b0001, 0, "fix_lock");
      drive(2, 0, 4'b1111, 4'b0001, 1, 4'b0001, 1, "fix_hold");
      drive(2, 1, 4'b1111, 4'b0001, 1, 4'b0001, 0, "fix_rst");
      drive(2, 0, 4'b0110, 4'b0000, 1, 4'b0010, 0, "fix_post");
      for (int k = 0; k < 10 && sb.size() > 0; k++)
         @(posedge clk);
      check("sb_drain", 32'(sb.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
